// File: rtl/rs_seq_decoder.sv
// Serial RS(15, 15-2T) decoder over GF(16), primitive x^4+x+1.
// Horner syndromes on input, one Berlekamp-Massey step per cycle, Chien search with in-line Forney.
module rs_seq_decoder #(
    parameter int T_CORR = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  sym_in,
    input  logic                        sym_valid,
    output logic                        sym_ready,
    output logic [4*(15-2*T_CORR)-1:0]  msg_out,
    output logic                        msg_valid,
    input  logic                        msg_ready,
    output logic [1:0]                  err_count,
    output logic                        uncorrectable,
    output logic                        busy
);
    localparam int K  = 15 - 2*T_CORR;
    localparam int NS = 2*T_CORR;
    localparam int NL = T_CORR + 2;
    localparam logic [3:0] BM_LAST = 4'(NS - 1);
    localparam logic [3:0] T_MAX   = 4'(T_CORR);
    localparam logic [3:0] ALPHA_POW [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                                              4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};
    localparam logic [3:0] INV_TAB [16]   = '{4'h0, 4'h1, 4'h9, 4'hE, 4'hD, 4'hB, 4'h7, 4'h6,
                                              4'hF, 4'h2, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h8};

    typedef enum logic [2:0] {IDLE, LOAD, BM, CHIEN, OUT} decStateT;

    function automatic logic [3:0] gfMul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'b0011 : 4'b0000);
        end
        return p;
    endfunction

    decStateT   state, stateNext;
    logic [3:0] cnt;
    logic [3:0] syn    [NS];
    logic [3:0] lam    [NL];
    logic [3:0] bPoly  [NL];
    logic [3:0] lenL;
    logic [3:0] xPow;
    logic [3:0] rootCnt;
    logic [3:0] symBuf [15];
    logic [3:0] errBuf [15];
    logic [1:0] errCount;
    logic       uncorr;

    logic [3:0] loadPos, delta;
    logic [3:0] pw, prevPw, omgCoef;
    logic [3:0] lamVal, derVal, omgVal, errVal;
    logic [3:0] rootNext;
    logic       isRoot, badFrame;

    assign loadPos   = 4'd14 - cnt;
    assign sym_ready = (state == IDLE) || (state == LOAD);
    assign msg_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign err_count = errCount;
    assign uncorrectable = uncorr;

    // BM discrepancy for step r = cnt+1: sum Lambda_i * S_(r-i)
    always_comb begin
        delta = 4'h0;
        for (int i = 0; i < NL; i++)
            for (int j = 0; j < NS; j++)
                if (int'(cnt) == i + j) delta = delta ^ gfMul(lam[i], syn[j]);
    end

    // Chien point xPow = alpha^-cnt; Lambda, Lambda' and Omega evaluated there
    always_comb begin
        lamVal  = 4'h0;
        derVal  = 4'h0;
        omgVal  = 4'h0;
        omgCoef = 4'h0;
        pw      = 4'h1;
        prevPw  = 4'h0;
        for (int k = 0; k < NL; k++) begin
            lamVal = lamVal ^ gfMul(lam[k], pw);
            if (k % 2 == 1) derVal = derVal ^ gfMul(lam[k], prevPw);
            prevPw = pw;
            pw     = gfMul(pw, xPow);
        end
        pw = 4'h1;
        for (int k = 0; k < NS; k++) begin
            omgCoef = 4'h0;
            for (int m = 0; m <= k && m < NL; m++)
                omgCoef = omgCoef ^ gfMul(lam[m], syn[k-m]);
            omgVal = omgVal ^ gfMul(omgCoef, pw);
            pw     = gfMul(pw, xPow);
        end
        errVal   = gfMul(omgVal, INV_TAB[derVal]);
        isRoot   = (lamVal == 4'h0);
        rootNext = rootCnt + {3'b000, isRoot};
        badFrame = (lenL > T_MAX) || (rootNext != lenL);
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (sym_valid) stateNext = LOAD;
            LOAD:    if (sym_valid && cnt == 4'd14) stateNext = BM;
            BM:      if (cnt == BM_LAST) stateNext = CHIEN;
            CHIEN:   if (cnt == 4'd14) stateNext = OUT;
            OUT:     if (msg_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 4'd0;
            lenL     <= 4'd0;
            xPow     <= 4'h1;
            rootCnt  <= 4'd0;
            errCount <= 2'd0;
            uncorr   <= 1'b0;
            for (int j = 0; j < NS; j++) syn[j] <= 4'h0;
            for (int k = 0; k < NL; k++) begin
                lam[k]   <= 4'h0;
                bPoly[k] <= 4'h0;
            end
            for (int p = 0; p < 15; p++) begin
                symBuf[p] <= 4'h0;
                errBuf[p] <= 4'h0;
            end
        end else begin
            case (state)
                IDLE, LOAD: if (sym_valid) begin
                    symBuf[loadPos] <= sym_in;
                    // first symbol of a frame restarts the syndrome accumulators
                    for (int j = 0; j < NS; j++)
                        syn[j] <= ((state == IDLE) ? 4'h0 : gfMul(syn[j], ALPHA_POW[j+1])) ^ sym_in;
                    cnt <= (cnt == 4'd14) ? 4'd0 : cnt + 4'd1;
                    if (state == IDLE) begin
                        lenL <= 4'd0;
                        for (int k = 0; k < NL; k++) begin
                            lam[k]   <= (k == 0) ? 4'h1 : 4'h0;
                            bPoly[k] <= (k == 0) ? 4'h1 : 4'h0;
                        end
                    end
                end
                BM: begin
                    for (int k = 1; k < NL; k++) lam[k] <= lam[k] ^ gfMul(delta, bPoly[k-1]);
                    if (delta != 4'h0 && {lenL, 1'b0} <= {1'b0, cnt}) begin
                        for (int k = 0; k < NL; k++) bPoly[k] <= gfMul(INV_TAB[delta], lam[k]);
                        lenL <= cnt + 4'd1 - lenL;
                    end else begin
                        bPoly[0] <= 4'h0;
                        for (int k = 1; k < NL; k++) bPoly[k] <= bPoly[k-1];
                    end
                    if (cnt == BM_LAST) begin
                        cnt     <= 4'd0;
                        xPow    <= 4'h1;
                        rootCnt <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CHIEN: begin
                    errBuf[cnt] <= isRoot ? errVal : 4'h0;
                    xPow        <= gfMul(xPow, 4'h9);
                    rootCnt     <= rootNext;
                    if (cnt == 4'd14) begin
                        cnt      <= 4'd0;
                        uncorr   <= badFrame;
                        errCount <= badFrame ? 2'd0 : rootNext[1:0];
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // corrections are kept apart from the raw symbols so a failed frame can emit them untouched
    always_comb begin
        msg_out = '0;
        for (int p = 0; p < K; p++)
            msg_out[4*p +: 4] = symBuf[p+NS] ^ (uncorr ? 4'h0 : errBuf[p+NS]);
    end
endmodule

// File: tb/tb_rs_seq_decoder.sv
// Directed bench for rs_seq_decoder: T_CORR=3 vector table plus T_CORR=1, stall and mid-frame reset sequences.
module tb_rs_seq_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  symIn3, symIn1;
    logic        symValid3, symValid1, msgReady3, msgReady1;
    logic        symReady3, symReady1, msgValid3, msgValid1;
    logic        unc3, unc1, busy3, busy1;
    logic [1:0]  errCnt3, errCnt1;
    logic [35:0] msgOut3;
    logic [51:0] msgOut1;
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [59:0] frame;   // nibble p = received position p
        logic [35:0] msg;
        logic [1:0]  err;
        logic        unc;
    } vecT;
    vecT vecs [9];

    always #5 clk = ~clk;

    rs_seq_decoder #(.T_CORR(3)) dut3 (
        .clk(clk), .rst(rst), .sym_in(symIn3), .sym_valid(symValid3), .sym_ready(symReady3),
        .msg_out(msgOut3), .msg_valid(msgValid3), .msg_ready(msgReady3),
        .err_count(errCnt3), .uncorrectable(unc3), .busy(busy3));

    rs_seq_decoder #(.T_CORR(1)) dut1 (
        .clk(clk), .rst(rst), .sym_in(symIn1), .sym_valid(symValid1), .sym_ready(symReady1),
        .msg_out(msgOut1), .msg_valid(msgValid1), .msg_ready(msgReady1),
        .err_count(errCnt1), .uncorrectable(unc1), .busy(busy1));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic sendFrame(input bit sel, input logic [59:0] f);
        for (int p = 14; p >= 0; p--) begin
            if (sel) begin symIn1 = f[4*p +: 4]; symValid1 = 1'b1; end
            else     begin symIn3 = f[4*p +: 4]; symValid3 = 1'b1; end
            @(posedge clk); #1;
        end
        symValid1 = 1'b0;
        symValid3 = 1'b0;
    endtask

    task automatic waitValid(input bit sel, output int lat);
        lat = 0;
        while (!(sel ? msgValid1 : msgValid3) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [35:0] held;
        // T_CORR=3 frames; constant words and r_i = alpha^i are codewords
        vecs[0] = '{60'h000000000000000, 36'h000000000, 2'd0, 1'b0};
        vecs[1] = '{60'h000050000000000, 36'h000000000, 2'd1, 1'b0};
        vecs[2] = '{60'h300000020000001, 36'h000000000, 2'd3, 1'b0};
        vecs[3] = '{60'h777777777777777, 36'h777777777, 2'd0, 1'b0};
        vecs[4] = '{60'h9DFE7A5BC638421, 36'h9DFE7A5BC, 2'd0, 1'b0};
        vecs[5] = '{60'hCDFE7A5B3638421, 36'h9DFE7A5BC, 2'd2, 1'b0};
        vecs[6] = '{60'h77777777777F773, 36'h777777777, 2'd2, 1'b0};
        vecs[7] = '{60'h00000000000000E, 36'h000000000, 2'd1, 1'b0};
        vecs[8] = '{60'h077777777777777, 36'h777777777, 2'd1, 1'b0};

        rst = 1'b1;
        symIn3 = 4'h0; symIn1 = 4'h0; symValid3 = 1'b0; symValid1 = 1'b0;
        msgReady3 = 1'b1; msgReady1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", msgValid3, 1'b0);
        check("rst.msg", msgOut3, 36'h0);
        check("rst.err", errCnt3, 2'd0);
        check("rst.unc", unc3, 1'b0);
        check("rst.busy", busy3, 1'b0);
        rst = 1'b0;
        #1;
        check("rst.ready3", symReady3, 1'b1);
        check("rst.ready1", symReady1, 1'b1);

        for (int i = 0; i < 9; i++) begin
            sendFrame(1'b0, vecs[i].frame);
            check($sformatf("v%0d.busy", i), busy3, 1'b1);
            waitValid(1'b0, lat);
            check($sformatf("v%0d.lat", i), lat, 21);
            check($sformatf("v%0d.msg", i), msgOut3, vecs[i].msg);
            check($sformatf("v%0d.err", i), errCnt3, vecs[i].err);
            check($sformatf("v%0d.unc", i), unc3, vecs[i].unc);
            @(posedge clk); #1;
            check($sformatf("v%0d.drop", i), msgValid3, 1'b0);
        end

        // T_CORR=1: S1=0, S2!=0 gives L=2, flagged and passed through raw
        sendFrame(1'b1, 60'h000000000000012);
        waitValid(1'b1, lat);
        check("t1fail.lat", lat, 17);
        check("t1fail.unc", unc1, 1'b1);
        check("t1fail.err", errCnt1, 2'd0);
        check("t1fail.msg", msgOut1, 52'h0);
        @(posedge clk); #1;
        sendFrame(1'b1, 60'h777770777777777);
        waitValid(1'b1, lat);
        check("t1one.msg", msgOut1, 52'h7777777777777);
        check("t1one.err", errCnt1, 2'd1);
        check("t1one.unc", unc1, 1'b0);
        @(posedge clk); #1;
        sendFrame(1'b1, 60'h9DFE7A5BC638021);
        waitValid(1'b1, lat);
        check("t1pat.msg", msgOut1, 52'h9DFE7A5BC6384);
        check("t1pat.err", errCnt1, 2'd1);
        @(posedge clk); #1;

        // downstream stall: result must hold and input must be refused
        msgReady3 = 1'b0;
        sendFrame(1'b0, 60'h777707777777777);
        waitValid(1'b0, lat);
        check("stall.lat", lat, 21);
        held = msgOut3;
        check("stall.msg", held, 36'h777777777);
        for (int c = 0; c < 5; c++) begin
            symIn3 = 4'($urandom);
            symValid3 = c[0];
            check($sformatf("stall%0d.ready", c), symReady3, 1'b0);
            @(posedge clk); #1;
            check($sformatf("stall%0d.valid", c), msgValid3, 1'b1);
            check($sformatf("stall%0d.msg", c), msgOut3, held);
            check($sformatf("stall%0d.err", c), errCnt3, 2'd1);
        end
        symValid3 = 1'b0;
        msgReady3 = 1'b1;
        @(posedge clk); #1;
        check("stall.release", msgValid3, 1'b0);
        check("stall.idle", busy3, 1'b0);

        // reset part way through a frame, then a clean frame
        for (int s = 0; s < 7; s++) begin
            symIn3 = 4'hA; symValid3 = 1'b1;
            @(posedge clk); #1;
        end
        symValid3 = 1'b0;
        check("abort.busy", busy3, 1'b1);
        rst = 1'b1;
        #1;
        check("abort.asyncBusy", busy3, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort.ready", symReady3, 1'b1);
        check("abort.err", errCnt3, 2'd0);
        check("abort.msg", msgOut3, 36'h0);
        sendFrame(1'b0, 60'h009000000000000);
        waitValid(1'b0, lat);
        check("after.lat", lat, 21);
        check("after.msg", msgOut3, 36'h0);
        check("after.err", errCnt3, 2'd1);
        check("after.unc", unc3, 1'b0);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rs_seq_decoder.md
RS_SEQ_DECODER -- requirements
Module: rs_seq_decoder

Interface
REQ-001 Parameter T_CORR, default 3, legal 1..3: correctable symbol errors; N fixed 15, K = 15-2*T_CORR, GF(16) with primitive x^4+x+1 (alpha^4 = 4'b0011), SHALL apply.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 sym_in  input  4  received symbol, highest position (r14) first.
REQ-005 sym_valid  input  1  sym_in valid.
REQ-006 sym_ready  output  1  decoder accepts a symbol this cycle.
REQ-007 msg_out  output  4*K  corrected message: codeword positions 2T..14, position 2T in bits [3:0].
REQ-008 msg_valid  output  1  msg_out, err_count and uncorrectable valid.
REQ-009 msg_ready  input  1  downstream accepts result.
REQ-010 err_count  output  2  number of symbols corrected (0..3).
REQ-011 uncorrectable  output  1  decoding failure flag.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, BM, CHIEN, OUT.
REQ-014 Symbol accepted only on a rising edge with sym_valid && sym_ready; sym_ready = 1 in IDLE and LOAD only.
REQ-015 First accepted symbol moves IDLE->LOAD; 4-bit counter SHALL count 15 accepted symbols, 15th moves LOAD->BM; sym_valid with sym_ready low is ignored.
REQ-016 Syndromes S1..S(2T) SHALL be updated per accepted symbol by Horner: Sj <= Sj*alpha^j ^ sym_in; symbols also stored in a 15x4 buffer.
REQ-017 BM SHALL run exactly 2*T_CORR cycles of Berlekamp-Massey, producing Lambda(x) (degree <= T_CORR+1 storage) and length L.
REQ-018 CHIEN SHALL run exactly 15 cycles, cycle i testing position i (0..14): Lambda(alpha^-i) == 0 marks an error.
REQ-019 Error value SHALL be computed in the same cycle by Forney (b=1): e = Omega(alpha^-i)/Lambda'(alpha^-i), Omega = S(x)*Lambda(x) mod x^(2T), S(x) = S1 + S2 x + ...; buffer[i] ^= e.
REQ-020 GF inverse by 16-entry table, inverse(0) = 0.
REQ-021 uncorrectable SHALL be 1 when L > T_CORR or Chien root count != L; then msg_out carries uncorrected buffer symbols and err_count = 0.
REQ-022 Otherwise err_count = root count; all-zero syndromes give err_count 0, uncorrectable 0.
REQ-023 Latency fixed regardless of error count: msg_valid rises after the (2T+15)th rising edge following the edge accepting the 15th symbol.
REQ-024 OUT: msg_valid = 1; msg_out, err_count, uncorrectable SHALL hold stable until msg_valid && msg_ready, then go to IDLE, msg_valid = 0 next cycle.
REQ-025 No new frame accepted while in BM, CHIEN or OUT (sym_ready = 0).
REQ-026 Parity positions 0..2T-1 SHALL be corrected internally and counted in err_count but not output.

Reset
REQ-027 rst SHALL immediately force IDLE and clear syndromes, Lambda, buffer and counters; outputs: sym_ready 1 (after rst deassert), msg_valid 0, msg_out 0, err_count 0, uncorrectable 0, busy 0.
REQ-028 rst mid-frame (any state) SHALL discard the partial frame; the next accepted symbol starts a fresh frame.

Verification
REQ-029 T_CORR=3, 15 zero symbols -> msg_out 0, err_count 0, uncorrectable 0, msg_valid after edge 21.
REQ-030 T_CORR=3, zero codeword with r10 = 4'h5 -> msg_out 0, err_count 1, uncorrectable 0.
REQ-031 T_CORR=3, zero codeword with r0=4'h1, r7=4'h2, r14=4'h3 -> msg_out 0, err_count 3, uncorrectable 0.
REQ-032 T_CORR=1, r0=4'h2, r1=4'h1, others 0 (S1=0, S2!=0) -> uncorrectable 1, err_count 0, msg_out 0 (positions 2..14 raw).
REQ-033 msg_ready held low 5 cycles in OUT -> msg_valid and outputs stable, sym_ready 0; sym_valid pulses ignored.
REQ-034 rst asserted after 7 symbols, then a full zero frame with r12 = 4'h9 -> msg_out 0, err_count 1; no residue from the aborted frame.
